// File: rtl/condicionador_entrada.sv
// Input conditioner: synchronizes a push-button and two level sensors, classifies button presses
// as short (b) or long (a), and flags sensor conflicts. Define CONDICIONADOR_SENSOR_DEB_EN to debounce the sensors.
module condicionador_entrada #(
    parameter int unsigned DEB_CYCLES  = 1000,
    parameter int unsigned LONG_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic sens_cheio,
    input  logic sens_vazio,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic erro
);

    localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned LongW = $clog2(LONG_CYCLES + 1);
    localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES);
    localparam logic [LongW-1:0] LongMax = LongW'(LONG_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StDebPress,
        StHeld,
        StLong,
        StDebRel
    } state_e;

    // Bit order: {btn, vazio, cheio}
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_raw, sens_vazio, sens_cheio};
            sync2_q <= sync1_q;
        end
    end

    logic btn_s;
    assign btn_s = sync2_q[2];

    state_e            state_q;
    logic [DebW-1:0]   deb_cnt_q, deb_inc;
    logic [LongW-1:0]  held_cnt_q, held_inc;
    logic              long_q;
    logic              a_q, b_q;

    always_comb begin
        deb_inc  = (deb_cnt_q >= DebMax) ? deb_cnt_q : deb_cnt_q + DebW'(1);
        held_inc = (held_cnt_q >= LongMax) ? held_cnt_q : held_cnt_q + LongW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            deb_cnt_q  <= '0;
            held_cnt_q <= '0;
            long_q     <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
        end else begin
            a_q <= 1'b0;
            b_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        state_q   <= StDebPress;
                        deb_cnt_q <= '0;
                    end
                end
                StDebPress: begin
                    if (!btn_s) begin
                        state_q <= StIdle;
                    end else if (deb_inc == DebMax) begin
                        state_q    <= StHeld;
                        deb_cnt_q  <= '0;
                        held_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_inc;
                    end
                end
                StHeld: begin
                    if (!btn_s) begin
                        state_q   <= StDebRel;
                        long_q    <= 1'b0;
                        deb_cnt_q <= '0;
                    end else begin
                        held_cnt_q <= held_inc;
                        if (held_inc == LongMax) begin
                            state_q <= StLong;
                            a_q     <= 1'b1;
                        end
                    end
                end
                StLong: begin
                    if (!btn_s) begin
                        state_q   <= StDebRel;
                        long_q    <= 1'b1;
                        deb_cnt_q <= '0;
                    end
                end
                StDebRel: begin
                    // A bounce back to 1 resumes the press without losing the held count
                    if (btn_s) begin
                        state_q <= long_q ? StLong : StHeld;
                    end else if (deb_inc == DebMax) begin
                        state_q   <= StIdle;
                        deb_cnt_q <= '0;
                        b_q       <= ~long_q;
                    end else begin
                        deb_cnt_q <= deb_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a = a_q;
    assign b = b_q;

    // Bit 0 = cheio, bit 1 = vazio
    logic [1:0] sens_v;

`ifdef CONDICIONADOR_SENSOR_DEB_EN
    logic [1:0]      sens_deb_q;
    logic [DebW-1:0] sens_cnt_q [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sens_deb_q <= '0;
            for (int i = 0; i < 2; i++) begin
                sens_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == sens_deb_q[i]) begin
                    sens_cnt_q[i] <= '0;
                end else if (sens_cnt_q[i] >= DebMax) begin
                    sens_deb_q[i] <= sync2_q[i];
                    sens_cnt_q[i] <= '0;
                end else begin
                    sens_cnt_q[i] <= sens_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    assign sens_v = sens_deb_q;
`else
    assign sens_v = sync2_q[1:0];
`endif

    assign c    = sens_v[0] & ~sens_v[1];
    assign d    = sens_v[1] & ~sens_v[0];
    assign erro = sens_v[0] & sens_v[1];

endmodule
